serial_sub: RTL and testbench
=============================

# serial_sub

Multi-cycle digit-serial subtractor and comparator for the integer datapath. It computes A − B together with the borrow, zero, overflow and signed/unsigned less-than flags needed by SUB, SLT/SLTU and branch compare. It processes one DIGIT_WIDTH-bit slice per clock with a registered borrow. Operands enter and results leave through valid/ready handshakes, so a branch unit or multi-cycle ALU can sit on either side.

## Interface
- DATA_WIDTH, 32, operand and result width.
- DIGIT_WIDTH, 4, bits processed per RUN cycle. Must divide DATA_WIDTH.
- i_clk  input  1  single clock. All state updates on the rising edge.
- i_rst_n  input  1  reset: one clock; reset is synchronous and active-low.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  block can accept operands. High only in IDLE.
- i_data_a  input  DATA_WIDTH  minuend A.
- i_data_b  input  DATA_WIDTH  subtrahend B.
- o_valid  output  1  result valid. High only in DONE.
- i_ready  input  1  downstream accepts the result.
- o_data  output  DATA_WIDTH  A − B, modulo 2^DATA_WIDTH.
- o_borrow  output  1  borrow out of the MSB. 1 iff unsigned A < B.
- o_zero  output  1  o_data == 0.
- o_overflow  output  1  signed overflow of A − B.
- o_lt_signed  output  1  signed A < B.
- o_lt_unsigned  output  1  unsigned A < B. Equals o_borrow.

## Operation
- N = DATA_WIDTH/DIGIT_WIDTH digit steps. Digit counter width is clog2(N).
- **IDLE:** o_ready=1.
  - i_valid && o_ready at an edge: latch A and ~B, set the carry register to 1, clear the counter, go to RUN.
- **RUN:** o_ready=0, o_valid=0.
  - Each edge: digit k = A[k] + ~B[k] + carry. Write the sum into result digit k, register the carry out, increment k.
  - The digit adds ripple internally.
  - At the edge where k == N−1, go to DONE and register the flags.
- **Flags, registered on entering DONE:**
  - o_borrow = ~final carry.
  - o_zero = (result == 0).
  - o_overflow = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]).
  - o_lt_signed = D[MSB] ^ o_overflow.
  - o_lt_unsigned = o_borrow.
- **DONE:** o_valid=1. o_data and all flags hold stable.
  - i_ready at an edge: go to IDLE. o_data and flags keep their values until the next DONE entry.
- i_valid is ignored outside IDLE. Operand inputs need only be stable on the accept edge.
- Operands are captured, so later changes to i_data_a/i_data_b do not affect a transaction in flight.

## Timing
- **Reset:** i_rst_n low at an edge clears everything. State goes to IDLE.
  - o_ready=1 after that edge.
  - o_valid, o_data, o_borrow, o_zero, o_overflow, o_lt_signed and o_lt_unsigned all 0.
  - Counter and carry cleared.
- **Reset mid-RUN or in DONE:** the transaction is discarded and no o_valid is produced.
- **Latency:** accept edge = edge 0. RUN occupies edges 1..N. o_valid goes high after edge N.
  - Default parameters: 8 cycles from accept to o_valid.
- **Throughput:** one transaction per N+2 cycles when i_ready is held high.
  - The DONE→IDLE edge consumes the result.
  - o_ready rises in the following cycle.
  - There is no same-cycle result/accept overlap.
- **Backpressure:** o_valid and the outputs hold indefinitely while i_ready=0. No timeout.
- **Handshake independence:** i_ready high in IDLE or RUN has no effect. i_valid high in RUN or DONE is not queued.
- **DIGIT_WIDTH == DATA_WIDTH:** N=1, and o_valid goes high after edge 1.

## Test plan
- **Basic subtraction:** A=5, B=3 → o_data=0x00000002. borrow=0, zero=0, overflow=0, lt_s=0, lt_u=0. o_valid high exactly 8 cycles after the accept edge.
- **Negative result:** A=3, B=5 → o_data=0xFFFFFFFE. borrow=1, lt_u=1, lt_s=1, overflow=0.
- **Signed overflow:** A=0x80000000, B=1 → o_data=0x7FFFFFFF. overflow=1, lt_s=1, lt_u=0, borrow=0.
- **Equality and sign compare:**
  - A=B=0xDEADBEEF → o_data=0, zero=1, all other flags 0.
  - A=0xFFFFFFFF, B=0 → lt_s=1, lt_u=0.
- **Handshake:**
  - Hold i_ready=0 for 5 cycles in DONE → o_data and flags unchanged, o_valid stays 1.
  - i_valid pulsed with new operands during RUN → ignored. Result still matches the first pair.
  - o_ready returns 1 one cycle after the i_ready edge.
- **Reset during RUN:** drop i_rst_n at the 4th RUN edge → after that edge, state IDLE, o_ready=1, o_valid=0, outputs 0.
  - A fresh transaction A=10, B=4 then yields 0x00000006 with normal latency.

Source files
------------

// File: rtl/serial_sub.sv
// serial_sub: digit-serial A - B with borrow, zero, overflow and signed/unsigned
// less-than flags. One DIGIT_WIDTH slice is added per RUN cycle using A + ~B + 1,
// with the inter-digit carry held in a register. Operands and results move
// through valid/ready handshakes.
module serial_sub #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DIGIT_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_borrow,
    output logic                  o_zero,
    output logic                  o_overflow,
    output logic                  o_lt_signed,
    output logic                  o_lt_unsigned
);

    localparam int unsigned NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
    // A single-digit configuration still needs a 1-bit counter to stay legal.
    localparam int unsigned CNT_WIDTH  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_DIGIT = CNT_WIDTH'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   nb_q;      // captured ~B
    logic [DATA_WIDTH-1:0]   work_q;    // partial difference built during RUN
    logic                    carry_q;
    logic [CNT_WIDTH-1:0]    cnt_q;

    // Output registers; kept separate from work_q so o_data holds through RUN.
    logic                    ready_q;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    borrow_q;
    logic                    zero_q;
    logic                    overflow_q;
    logic                    lt_signed_q;

    logic [DIGIT_WIDTH-1:0]  a_digit;
    logic [DIGIT_WIDTH-1:0]  nb_digit;
    logic [DIGIT_WIDTH:0]    digit_sum;
    logic [DATA_WIDTH-1:0]   work_d;
    logic                    carry_out;
    logic                    sign_a;
    logic                    sign_b;
    logic                    sign_d;
    logic                    overflow_d;
    logic                    zero_d;

    // Select the active digit and ripple-add it with the registered carry.
    always_comb begin
        a_digit  = '0;
        nb_digit = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (cnt_q == CNT_WIDTH'(k)) begin
                a_digit  = a_q[k*DIGIT_WIDTH +: DIGIT_WIDTH];
                nb_digit = nb_q[k*DIGIT_WIDTH +: DIGIT_WIDTH];
            end
        end
        digit_sum = {1'b0, a_digit} + {1'b0, nb_digit} + {{DIGIT_WIDTH{1'b0}}, carry_q};
        carry_out = digit_sum[DIGIT_WIDTH];
    end

    // Merge the fresh digit into the partial difference.
    always_comb begin
        work_d = work_q;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (cnt_q == CNT_WIDTH'(k)) begin
                work_d[k*DIGIT_WIDTH +: DIGIT_WIDTH] = digit_sum[DIGIT_WIDTH-1:0];
            end
        end
    end

    // Flags derived from the complete difference, valid on the last RUN cycle.
    always_comb begin
        sign_a     = a_q[DATA_WIDTH-1];
        sign_b     = ~nb_q[DATA_WIDTH-1];
        sign_d     = work_d[DATA_WIDTH-1];
        overflow_d = (sign_a != sign_b) && (sign_d != sign_a);
        zero_d     = (work_d == '0);
    end

    // Control FSM with datapath and registered handshake/result outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            nb_q        <= '0;
            work_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            data_q      <= '0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            lt_signed_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid && ready_q) begin
                        a_q     <= i_data_a;
                        nb_q    <= ~i_data_b;
                        work_q  <= '0;
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    work_q  <= work_d;
                    carry_q <= carry_out;
                    cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == LAST_DIGIT) begin
                        cnt_q       <= '0;
                        valid_q     <= 1'b1;
                        data_q      <= work_d;
                        borrow_q    <= ~carry_out;
                        zero_q      <= zero_d;
                        overflow_q  <= overflow_d;
                        lt_signed_q <= sign_d ^ overflow_d;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    // Result and flags keep their values after the handoff.
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_ready       = ready_q;
    assign o_valid       = valid_q;
    assign o_data        = data_q;
    assign o_borrow      = borrow_q;
    assign o_zero        = zero_q;
    assign o_overflow    = overflow_q;
    assign o_lt_signed   = lt_signed_q;
    assign o_lt_unsigned = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: directed operand pairs with hand-computed results pushed
// into a scoreboard; a monitor pops and compares on each result handoff.
module tb_serial_sub;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_borrow;
    logic        o_zero;
    logic        o_overflow;
    logic        o_lt_signed;
    logic        o_lt_unsigned;

    typedef struct packed {
        logic [31:0] data;
        logic        borrow;
        logic        zero;
        logic        ovf;
        logic        lts;
        logic        ltu;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    serial_sub #(
        .DATA_WIDTH (32),
        .DIGIT_WIDTH(4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data_a     (i_data_a),
        .i_data_b     (i_data_b),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_borrow     (o_borrow),
        .o_zero       (o_zero),
        .o_overflow   (o_overflow),
        .o_lt_signed  (o_lt_signed),
        .o_lt_unsigned(o_lt_unsigned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, req);
    endtask

    // Monitor: compare every result handoff against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got 0x%08h, expected no result", o_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_word("data", o_data, e.data);
                check_bit("borrow", o_borrow, e.borrow);
                check_bit("zero", o_zero, e.zero);
                check_bit("overflow", o_overflow, e.ovf);
                check_bit("lt_signed", o_lt_signed, e.lts);
                check_bit("lt_unsigned", o_lt_unsigned, e.ltu);
            end
        end
    end

    task automatic check_idle_zero(input string tag);
        check_bit({tag, "_ready"}, o_ready, 1'b1);
        check_bit({tag, "_valid"}, o_valid, 1'b0);
        check_word({tag, "_data"}, o_data, 32'h0);
        check_word({tag, "_flags"},
                   32'({o_borrow, o_zero, o_overflow, o_lt_signed, o_lt_unsigned}), 32'h0);
    endtask

    // Wait for o_ready, present one operand pair, return just after the accept edge.
    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!o_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_bit("ready_before_accept", o_ready, 1'b1);
        i_data_a = a;
        i_data_b = b;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid  = 1'b0;
        // Scramble operand inputs to show they were captured.
        i_data_a = 32'hA5A5_A5A5;
        i_data_b = 32'h5A5A_5A5A;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full transaction with i_ready held high: latency and ready-return checks.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int lat;
        sb_q.push_back(e);
        accept(a, b);
        wait_valid(lat);
        check_word("latency", 32'(lat), 32'd8);
        @(posedge clk);
        #1;
        check_bit("ready_return", o_ready, 1'b1);
        check_bit("valid_drop", o_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   lat;

        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_data_a = '0;
        i_data_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_txn(32'd5, 32'd3, '{data: 32'h0000_0002, borrow: 0, zero: 0, ovf: 0, lts: 0, ltu: 0});
        run_txn(32'd3, 32'd5, '{data: 32'hFFFF_FFFE, borrow: 1, zero: 0, ovf: 0, lts: 1, ltu: 1});
        run_txn(32'h8000_0000, 32'd1,
                '{data: 32'h7FFF_FFFF, borrow: 0, zero: 0, ovf: 1, lts: 1, ltu: 0});
        run_txn(32'hDEAD_BEEF, 32'hDEAD_BEEF,
                '{data: 32'h0000_0000, borrow: 0, zero: 1, ovf: 0, lts: 0, ltu: 0});
        run_txn(32'hFFFF_FFFF, 32'h0,
                '{data: 32'hFFFF_FFFF, borrow: 0, zero: 0, ovf: 0, lts: 1, ltu: 0});
        // Max positive minus -1: overflows, signed not-less, unsigned less.
        run_txn(32'h7FFF_FFFF, 32'hFFFF_FFFF,
                '{data: 32'h8000_0000, borrow: 1, zero: 0, ovf: 1, lts: 0, ltu: 1});

        // Backpressure: outputs hold while i_ready is low in DONE.
        e = '{data: 32'h1234_5600, borrow: 0, zero: 0, ovf: 0, lts: 0, ltu: 0};
        sb_q.push_back(e);
        i_ready = 1'b0;
        accept(32'h1234_5678, 32'h0000_0078);
        wait_valid(lat);
        check_word("bp_latency", 32'(lat), 32'd8);
        repeat (5) begin
            @(posedge clk);
            #1;
            check_bit("bp_valid", o_valid, 1'b1);
            check_bit("bp_ready", o_ready, 1'b0);
            check_word("bp_data", o_data, e.data);
            check_word("bp_flags",
                       32'({o_borrow, o_zero, o_overflow, o_lt_signed, o_lt_unsigned}), 32'h0);
        end
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        check_bit("bp_ready_return", o_ready, 1'b1);
        check_word("bp_data_after", o_data, e.data);

        // i_valid pulsed with other operands during RUN must be ignored.
        sb_q.push_back('{data: 32'h0000_0063, borrow: 0, zero: 0, ovf: 0, lts: 0, ltu: 0});
        accept(32'd100, 32'd1);
        lat = 0;
        while (!o_valid && lat < 100) begin
            if (lat == 2) begin
                i_valid  = 1'b1;
                i_data_a = 32'hFFFF_FFFF;
                i_data_b = 32'h0000_0001;
            end
            if (lat == 3) check_bit("run_ready_low", o_ready, 1'b0);
            if (lat == 5) i_valid = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        i_valid = 1'b0;
        check_word("pulse_latency", 32'(lat), 32'd8);
        @(posedge clk);
        #1;
        check_bit("pulse_ready_return", o_ready, 1'b1);

        // Reset asserted for the 4th RUN edge discards the transaction.
        accept(32'h0000_0055, 32'h0000_0011);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_idle_zero("midrun_reset");
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            check_bit("no_valid_after_reset", o_valid, 1'b0);
        end

        run_txn(32'd10, 32'd4, '{data: 32'h0000_0006, borrow: 0, zero: 0, ovf: 0, lts: 0, ltu: 0});

        repeat (3) @(posedge clk);
        #1;
        check_word("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
